axis_governor: RTL and testbench

Debug throttle inserted on the fetch→decode handshake of the axis_cpu controller, between `to_guv_TVALID/TREADY` and `from_guv_TVALID/TREADY`. It passes instructions at zero latency when running. It can pause the pipeline, single-step or N-step it, and halt on a code-address breakpoint. A 32-bit command word drives it and it reports status flags and a retired-handshake count; when debugging is disabled, axis_cpu wires the two handshakes together and omits this block.

---
 rtl/axis_governor_pkg.sv | 28 ++
 rtl/axis_governor.sv | 190 +++++++++++++++++++
 tb/tb_axis_governor.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_governor_pkg.sv
// -----------------------------------------------------------------------------
// axis_governor_pkg
//   Shared definitions for the axis_governor debug throttle: command opcodes
//   carried in cmd_TDATA[31:28], the governor state encoding and the command
//   field positions.
// -----------------------------------------------------------------------------
package axis_governor_pkg;

   // Command opcodes (cmd_TDATA[31:28]); any other value is ignored.
   localparam logic [3:0] GOV_OP_PAUSE   = 4'd0;
   localparam logic [3:0] GOV_OP_RUN     = 4'd1;
   localparam logic [3:0] GOV_OP_STEP    = 4'd2;
   localparam logic [3:0] GOV_OP_SET_BP  = 4'd3;
   localparam logic [3:0] GOV_OP_CLR_BP  = 4'd4;
   localparam logic [3:0] GOV_OP_CLR_CNT = 4'd5;

   // Command word field positions.
   localparam int unsigned GovOpMsb  = 31;
   localparam int unsigned GovOpLsb  = 28;
   localparam int unsigned GovArgMsb = 15;

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StStep   = 2'd1,
      StPaused = 2'd2
   } gov_state_e;

endpackage

// File: rtl/axis_governor.sv
// -----------------------------------------------------------------------------
// axis_governor
//   Debug throttle on the fetch->decode valid/ready handshake. Passes the
//   handshake combinationally (zero latency) while allowed; can pause, single-
//   or N-step the pipeline and halt on a code-address breakpoint. Reports
//   pause/breakpoint status and counts retired handshakes.
//
//   Optional feature macro: GOVERNOR_BREAKPOINT_EN
//     defined   : breakpoint compare, SET_BP/CLR_BP and bp_hit are present
//     undefined : no breakpoint; opcodes 3/4 ignored, bp_hit tied 0,
//                 inst_addr unused
//
//   Ports
//     clk, rst          sole clock, synchronous active-high reset
//     in_TVALID/TREADY  fetch side of the handshake
//     out_TVALID/TREADY decode side of the handshake
//     inst_addr         PC of the instruction offered on in_*
//     cmd_TDATA/TVALID  command word ([31:28] opcode, [15:0] argument)
//     cmd_TREADY        1 out of reset, 0 while rst
//     paused            state is PAUSED
//     bp_hit            sticky: last pause caused by the breakpoint
//     instr_count       handshakes passed since reset / CLR_CNT
// -----------------------------------------------------------------------------
module axis_governor
   import axis_governor_pkg::*;
#(
   parameter int unsigned CODE_ADDR_WIDTH = 10,
   parameter int unsigned CNT_WIDTH       = 32,
   parameter bit          START_PAUSED    = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_TVALID,
   output logic                       in_TREADY,
   output logic                       out_TVALID,
   input  logic                       out_TREADY,
   input  logic [CODE_ADDR_WIDTH-1:0] inst_addr,
   input  logic [31:0]                cmd_TDATA,
   input  logic                       cmd_TVALID,
   output logic                       cmd_TREADY,
   output logic                       paused,
   output logic                       bp_hit,
   output logic [CNT_WIDTH-1:0]       instr_count
);

   gov_state_e           state_q, state_d;
   logic [15:0]          step_left_q, step_left_d;
   logic [CNT_WIDTH-1:0] instr_count_q, instr_count_d;

   logic        allow;
   logic        fire;
   logic        bp_match;
   logic [3:0]  cmd_op;
   logic [15:0] cmd_arg;

   assign cmd_op  = cmd_TDATA[GovOpMsb:GovOpLsb];
   assign cmd_arg = cmd_TDATA[GovArgMsb:0];

   // Bits 27:16 of the command word carry nothing.
   logic unused_cmd_bits;
   assign unused_cmd_bits = ^cmd_TDATA[GovOpLsb-1:GovArgMsb+1];

`ifdef GOVERNOR_BREAKPOINT_EN
   logic [CODE_ADDR_WIDTH-1:0] bp_addr_q, bp_addr_d;
   logic                       bp_vld_q, bp_vld_d;
   logic                       bp_skip_q, bp_skip_d;
   logic                       bp_hit_q, bp_hit_d;

   // bp_skip lets the instruction that tripped the breakpoint pass once on resume.
   assign bp_match = bp_vld_q & in_TVALID & (inst_addr == bp_addr_q) & ~bp_skip_q;
   assign bp_hit   = bp_hit_q;
`else
   assign bp_match = 1'b0;
   assign bp_hit   = 1'b0;

   logic unused_inst_addr;
   assign unused_inst_addr = ^inst_addr;
`endif

   always_comb begin
      allow = 1'b0;
      unique case (state_q)
         StRun:    allow = ~bp_match;
         StStep:   allow = (step_left_q != 16'd0) & ~bp_match;
         StPaused: allow = 1'b0;
         default:  allow = 1'b0;
      endcase
   end

   // Combinational pass-through; with allow low both sides see a stall.
   assign out_TVALID = in_TVALID & allow;
   assign in_TREADY  = out_TREADY & allow;
   assign fire       = in_TVALID & out_TREADY & allow;

   assign cmd_TREADY  = ~rst;
   assign paused      = (state_q == StPaused);
   assign instr_count = instr_count_q;

   // Fire/breakpoint updates first, then command updates override them.
   always_comb begin
      state_d       = state_q;
      step_left_d   = step_left_q;
      instr_count_d = instr_count_q;
`ifdef GOVERNOR_BREAKPOINT_EN
      bp_addr_d     = bp_addr_q;
      bp_vld_d      = bp_vld_q;
      bp_skip_d     = bp_skip_q;
      bp_hit_d      = bp_hit_q;
`endif

      if (fire) begin
         instr_count_d = instr_count_q + CNT_WIDTH'(1);
`ifdef GOVERNOR_BREAKPOINT_EN
         bp_skip_d     = 1'b0;
`endif
         if (state_q == StStep) begin
            step_left_d = step_left_q - 16'd1;
            if (step_left_q == 16'd1) begin
               state_d = StPaused;
            end
         end
      end

`ifdef GOVERNOR_BREAKPOINT_EN
      if (bp_match && (state_q != StPaused) && !cmd_TVALID) begin
         state_d   = StPaused;
         bp_hit_d  = 1'b1;
         bp_skip_d = 1'b1;
      end
`endif

      if (cmd_TVALID) begin
         case (cmd_op)
            GOV_OP_PAUSE: state_d = StPaused;
            GOV_OP_RUN: begin
               state_d = StRun;
`ifdef GOVERNOR_BREAKPOINT_EN
               bp_hit_d = 1'b0;
`endif
            end
            GOV_OP_STEP: begin
               if (cmd_arg != 16'd0) begin
                  state_d     = StStep;
                  step_left_d = cmd_arg;
`ifdef GOVERNOR_BREAKPOINT_EN
                  bp_hit_d    = 1'b0;
`endif
               end else begin
                  state_d = StPaused;
               end
            end
`ifdef GOVERNOR_BREAKPOINT_EN
            GOV_OP_SET_BP: begin
               bp_addr_d = cmd_arg[CODE_ADDR_WIDTH-1:0];
               bp_vld_d  = 1'b1;
               bp_skip_d = 1'b0;
            end
            GOV_OP_CLR_BP: bp_vld_d = 1'b0;
`endif
            GOV_OP_CLR_CNT: instr_count_d = '0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= START_PAUSED ? StPaused : StRun;
         step_left_q   <= 16'd0;
         instr_count_q <= '0;
`ifdef GOVERNOR_BREAKPOINT_EN
         bp_addr_q     <= '0;
         bp_vld_q      <= 1'b0;
         bp_skip_q     <= 1'b0;
         bp_hit_q      <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         step_left_q   <= step_left_d;
         instr_count_q <= instr_count_d;
`ifdef GOVERNOR_BREAKPOINT_EN
         bp_addr_q     <= bp_addr_d;
         bp_vld_q      <= bp_vld_d;
         bp_skip_q     <= bp_skip_d;
         bp_hit_q      <= bp_hit_d;
`endif
      end
   end

endmodule

// File: tb/tb_axis_governor.sv
// -----------------------------------------------------------------------------
// tb_axis_governor
//   Self-checking bench for axis_governor. A small fetch source advances its PC
//   on every accepted handshake; the addresses expected to pass are queued up
//   front and popped as the decode side sees each transfer. Breakpoint cases
//   follow GOVERNOR_BREAKPOINT_EN.
// -----------------------------------------------------------------------------
module tb_axis_governor;
   import axis_governor_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_TVALID;
   logic        in_TREADY;
   logic        out_TVALID;
   logic        out_TREADY;
   logic [9:0]  inst_addr;
   logic [31:0] cmd_TDATA;
   logic        cmd_TVALID;
   logic        cmd_TREADY;
   logic        paused;
   logic        bp_hit;
   logic [31:0] instr_count;

   int          total = 0;
   int          bad   = 0;
   logic [9:0]  pc    = 10'd0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   axis_governor #(
      .CODE_ADDR_WIDTH(10),
      .CNT_WIDTH      (32),
      .START_PAUSED   (1'b0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_TVALID  (in_TVALID),
      .in_TREADY  (in_TREADY),
      .out_TVALID (out_TVALID),
      .out_TREADY (out_TREADY),
      .inst_addr  (inst_addr),
      .cmd_TDATA  (cmd_TDATA),
      .cmd_TVALID (cmd_TVALID),
      .cmd_TREADY (cmd_TREADY),
      .paused     (paused),
      .bp_hit     (bp_hit),
      .instr_count(instr_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Queue the next n addresses the source will offer.
   task automatic push_n(input int n);
      logic [9:0] base;
      base = pc + 10'(4 * exp_q.size());
      for (int k = 0; k < n; k++) exp_q.push_back({22'd0, base + 10'(4 * k)});
   endtask

   // One clock: observe the decode side mid-cycle, advance the source after the edge.
   task automatic tick();
      logic        fired;
      logic [31:0] exp;
      @(negedge clk);
      fired = in_TVALID && in_TREADY;
      if (out_TVALID && out_TREADY) begin
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
         check("sb_addr", {22'd0, inst_addr}, {32'd0, exp});
      end
      @(posedge clk);
      #1;
      if (fired) pc = pc + 10'd4;
      inst_addr = pc;
   endtask

   task automatic send_cmd(input logic [3:0] op, input logic [15:0] arg);
      cmd_TDATA  = {op, 12'd0, arg};
      cmd_TVALID = 1'b1;
      tick();
      cmd_TVALID = 1'b0;
      cmd_TDATA  = 32'd0;
   endtask

   task automatic set_pc(input logic [9:0] a);
      pc        = a;
      inst_addr = a;
   endtask

   initial begin
      rst        = 1'b1;
      in_TVALID  = 1'b0;
      out_TREADY = 1'b0;
      inst_addr  = 10'd0;
      cmd_TDATA  = 32'd0;
      cmd_TVALID = 1'b0;
      repeat (3) tick();
      check("rst_cmd_tready", cmd_TREADY, 0);
      rst = 1'b0;
      #1;
      check("rst_paused", paused, 0);
      check("rst_bp_hit", bp_hit, 0);
      check("rst_count", instr_count, 0);
      check("rst_cmd_tready_out", cmd_TREADY, 1);

      // Free run: 20 back-to-back transfers.
      out_TREADY = 1'b1;
      in_TVALID  = 1'b1;
      push_n(20);
      for (int i = 0; i < 20; i++) begin
         #1;
         check("run_out_vld", out_TVALID, in_TVALID);
         tick();
      end
      check("run_count20", instr_count, 20);

      // Bubbly source: out_TVALID follows in_TVALID within the cycle.
      push_n(3);
      for (int i = 0; i < 6; i++) begin
         in_TVALID = (i % 2) == 1;
         #1;
         check("bubble_out_vld", out_TVALID, in_TVALID);
         tick();
      end
      in_TVALID = 1'b0;
      check("bubble_count", instr_count, 23);

      // PAUSE then STEP 3.
      send_cmd(GOV_OP_PAUSE, 16'd0);
      check("pause_paused", paused, 1);
      in_TVALID = 1'b1;
      #1;
      check("pause_in_rdy", in_TREADY, 0);
      check("pause_out_vld", out_TVALID, 0);
      repeat (3) tick();
      push_n(3);
      send_cmd(GOV_OP_STEP, 16'd3);
      tick();
      tick();
      check("step3_mid_paused", paused, 0);
      tick();
      check("step3_end_paused", paused, 1);
      #1;
      check("step3_in_rdy", in_TREADY, 0);
      repeat (2) tick();
      check("step3_count", instr_count, 26);

      // STEP 1 with decode stalled: nothing consumed until ready rises.
      out_TREADY = 1'b0;
      send_cmd(GOV_OP_STEP, 16'd1);
      repeat (3) tick();
      check("step1_stall_paused", paused, 0);
      check("step1_stall_out_vld", out_TVALID, 1);
      push_n(1);
      out_TREADY = 1'b1;
      tick();
      check("step1_done_paused", paused, 1);
      check("step1_count", instr_count, 27);

      // PAUSE in the same cycle as a transfer: that transfer still counts.
      send_cmd(GOV_OP_RUN, 16'd0);
      push_n(2);
      tick();
      send_cmd(GOV_OP_PAUSE, 16'd0);
      repeat (2) tick();
      check("pause_fire_paused", paused, 1);
      check("pause_fire_count", instr_count, 29);

      // CLR_CNT in the same cycle as a transfer wins.
      push_n(1);
      send_cmd(GOV_OP_RUN, 16'd0);
      send_cmd(GOV_OP_CLR_CNT, 16'd0);
      check("clr_fire_count", instr_count, 0);
      push_n(1);
      tick();
      check("clr_after_count", instr_count, 1);
      in_TVALID = 1'b0;
      send_cmd(GOV_OP_CLR_CNT, 16'd0);
      check("clr_idle_count", instr_count, 0);

`ifdef GOVERNOR_BREAKPOINT_EN
      // Breakpoint at 0x040, source ramps from 0x03C.
      set_pc(10'h03C);
      send_cmd(GOV_OP_SET_BP, 16'h0040);
      send_cmd(GOV_OP_RUN, 16'd0);
      push_n(1);
      in_TVALID = 1'b1;
      tick();
      #1;
      check("bp_block_in_rdy", in_TREADY, 0);
      tick();
      check("bp_paused", paused, 1);
      check("bp_hit_set", bp_hit, 1);
      repeat (2) tick();
      check("bp_hold_addr", inst_addr, 10'h040);
      push_n(3);
      send_cmd(GOV_OP_RUN, 16'd0);
      repeat (3) tick();
      check("bp_resume_hit", bp_hit, 0);
      check("bp_resume_paused", paused, 0);
      check("bp_resume_count", instr_count, 4);
      in_TVALID = 1'b0;
      send_cmd(GOV_OP_CLR_BP, 16'd0);
      set_pc(10'h040);
      push_n(1);
      in_TVALID = 1'b1;
      tick();
      in_TVALID = 1'b0;
      check("clrbp_paused", paused, 0);
      check("clrbp_count", instr_count, 5);
`else
      // Without breakpoint support SET_BP is ignored.
      set_pc(10'h03C);
      send_cmd(GOV_OP_SET_BP, 16'h0040);
      push_n(3);
      in_TVALID = 1'b1;
      repeat (3) tick();
      in_TVALID = 1'b0;
      check("nobp_hit", bp_hit, 0);
      check("nobp_paused", paused, 0);
      check("nobp_count", instr_count, 3);
`endif

      // Reset in the middle of STEP 5 after two transfers.
`ifdef GOVERNOR_BREAKPOINT_EN
      send_cmd(GOV_OP_SET_BP, 16'h0200);
`endif
      send_cmd(GOV_OP_PAUSE, 16'd0);
      send_cmd(GOV_OP_STEP, 16'd5);
      push_n(2);
      in_TVALID = 1'b1;
      repeat (2) tick();
      check("midstep_paused", paused, 0);
      rst       = 1'b1;
      in_TVALID = 1'b0;
      #1;
      check("midrst_cmd_tready", cmd_TREADY, 0);
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_paused", paused, 0);
      check("post_rst_bp_hit", bp_hit, 0);
      check("post_rst_count", instr_count, 0);
      check("post_rst_cmd_tready", cmd_TREADY, 1);
      set_pc(10'h200);
      push_n(2);
      in_TVALID = 1'b1;
      repeat (2) tick();
      in_TVALID = 1'b0;
      #1;
      check("post_rst_run_count", instr_count, 2);
      check("post_rst_paused2", paused, 0);
      check("sb_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
